cpa_word_serial_sequencer: RTL

//   Sequences one BIT_LEN-wide parallel-prefix adder (brent_kung_adder) over
//   NUM_WORDS-word operands, least-significant word first, to form wide sums.
//   The carry is held in a register between words, so one small adder serves

---
 rtl/cpa_word_serial_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cpa_word_serial_sequencer.sv
// Word-serial wide adder: one BIT_LEN-bit Brent-Kung adder is stepped over
// NUM_WORDS words (LSW first) with the inter-word carry kept in a register.

module brent_kung_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   s
);
  localparam int TOP = (W > 1) ? (1 << ($clog2(W) - 1)) : 1;

  logic [W-1:0] p;
  logic [W-1:0] gg;
  logic [W-1:0] pp;

  always_comb begin
    p  = a ^ b;
    gg = a & b;
    pp = p;
    // Up-sweep builds group prefixes at 2^k-1; down-sweep fills the gaps.
    for (int d = 1; d < W; d = d * 2) begin
      for (int i = 2 * d - 1; i < W; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
        pp[i] = pp[i] & pp[i-d];
      end
    end
    for (int d = TOP; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < W; i = i + 2 * d) begin
        gg[i] = gg[i] | (pp[i] & gg[i-d]);
      end
    end
    s[0] = p[0];
    for (int i = 1; i < W; i++) begin
      s[i] = p[i] ^ gg[i-1];
    end
    s[W] = gg[W-1];
  end
endmodule

module cpa_word_serial_sequencer #(
  parameter int BIT_LEN   = 16,
  parameter int NUM_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_WORDS*BIT_LEN-1:0]   in_a,
  input  logic [NUM_WORDS*BIT_LEN-1:0]   in_b,
  input  logic                           in_cin,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_WORDS*BIT_LEN-1:0]   out_sum,
  output logic                           out_carry,
  output logic                           busy
);
  localparam int TOTAL = NUM_WORDS * BIT_LEN;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [TOTAL-1:0]   a_reg, b_reg, sum_reg;
  logic               carry_reg;
  logic [IDX_W-1:0]   idx_reg;

  logic [BIT_LEN-1:0] word_a, word_b, word_sum;
  logic [BIT_LEN:0]   adder_s;
  logic               carry_next;
  logic               last_word;

  generate
    if (NUM_WORDS == 1) begin : g_single
      assign word_a = a_reg;
      assign word_b = b_reg;
    end else begin : g_multi
      logic [BIT_LEN-1:0] a_words [NUM_WORDS];
      logic [BIT_LEN-1:0] b_words [NUM_WORDS];
      for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        assign a_words[gi] = a_reg[gi*BIT_LEN +: BIT_LEN];
        assign b_words[gi] = b_reg[gi*BIT_LEN +: BIT_LEN];
      end
      assign word_a = a_words[idx_reg];
      assign word_b = b_words[idx_reg];
    end
  endgenerate

  brent_kung_adder #(.W(BIT_LEN)) u_adder (
    .a (word_a),
    .b (word_b),
    .s (adder_s)
  );

  // The stored carry is folded in after the adder; an all-ones word
  // propagates it onward to the next word.
  assign word_sum   = adder_s[BIT_LEN-1:0] + {{(BIT_LEN-1){1'b0}}, carry_reg};
  assign carry_next = adder_s[BIT_LEN] | (carry_reg & (&adder_s[BIT_LEN-1:0]));
  assign last_word  = (idx_reg == IDX_W'(NUM_WORDS - 1));

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_word) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_sum   = sum_reg;
  assign out_carry = carry_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && in_valid) begin
        a_reg     <= in_a;
        b_reg     <= in_b;
        carry_reg <= in_cin;
        idx_reg   <= '0;
      end else if (state_reg == RUN) begin
        for (int w = 0; w < NUM_WORDS; w++) begin
          if (idx_reg == IDX_W'(w)) sum_reg[w*BIT_LEN +: BIT_LEN] <= word_sum;
        end
        carry_reg <= carry_next;
        idx_reg   <= last_word ? '0 : idx_reg + 1'b1;
      end
    end
  end
endmodule
